freq_meas_seq: RTL and testbench

//  Measurement sequencer for the equal-precision frequency counter, in the sys_clk domain.
//  - Drives the software gate gate_s to the counter datapath.
//  - Waits for the cross-domain counts to settle, then samples cnt_test/cnt_stand.
//  - Computes freq = CLK_STAND_FREQ*cnt_test/cnt_stand with a serial divider.
//  - Supports single-shot or continuous runs with 4-step auto-ranging of gate length.

---
 rtl/freq_meas_seq.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_freq_meas_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meas_seq.sv
// -----------------------------------------------------------------------------
// freq_meas_seq
//   Measurement sequencer for an equal-precision frequency counter. Runs
//   entirely in the sys_clk domain.
//   - Drives the software gate (gate_s) for the counter datapath.
//   - Waits for the cross-domain counts to settle, then samples them.
//   - Computes freq = CLK_STAND_FREQ * cnt_test / cnt_stand with a serial
//     restoring divider (one quotient bit per cycle).
//   - Supports single-shot or continuous runs, and a 4-step auto-range that
//     scales the gate length by 4 per step.
//
// Ports
//   sys_clk       in   1   system clock
//   sys_rst       in   1   asynchronous active-high reset
//   start         in   1   1-cycle request, accepted only when idle
//   abort         in   1   level; forces idle, no result published
//   cont_mode     in   1   re-arm automatically after each result
//   auto_en       in   1   enable auto-ranging
//   range_init    in   2   range loaded when start is accepted
//   cnt_test_reg  in   28  latched clk_test count
//   cnt_stand_reg in   28  latched clk_stand count
//   gate_s        out  1   software gate, registered
//   busy          out  1   high whenever not idle
//   range_cur     out  2   active range; gate = GATE_BASE << (2*range_cur)
//   freq          out  34  last valid frequency in Hz
//   freq_valid    out  1   1-cycle pulse when freq updates
//   err_zero      out  1   1-cycle pulse when cnt_stand_reg was zero
// -----------------------------------------------------------------------------
module freq_meas_seq #(
  parameter logic [27:0] CLK_STAND_FREQ = 28'd60_000_000,
  parameter logic [27:0] GATE_BASE      = 28'd375_000,
  parameter logic [27:0] LEAD_CYC       = 28'd3_000_000,
  parameter logic [27:0] SETTLE_CYC     = 28'd3_000_000,
  parameter logic [27:0] MIN_CNT        = 28'd1_000,
  parameter logic [27:0] MAX_CNT        = 28'd200_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        abort,
  input  logic        cont_mode,
  input  logic        auto_en,
  input  logic [1:0]  range_init,
  input  logic [27:0] cnt_test_reg,
  input  logic [27:0] cnt_stand_reg,
  output logic        gate_s,
  output logic        busy,
  output logic [1:0]  range_cur,
  output logic [33:0] freq,
  output logic        freq_valid,
  output logic        err_zero
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DIV    = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Gate length for a given range: GATE_BASE * 4^range.
  function automatic logic [27:0] gate_len(input logic [1:0] r);
    gate_len = GATE_BASE << {r, 1'b0};
  endfunction

  // Quotients that do not fit in 34 bits clamp to all-ones.
  function automatic logic [33:0] sat_freq(input logic [55:0] q);
    if (q[55:34] != 22'd0) begin
      sat_freq = 34'h3_FFFF_FFFF;
    end else begin
      sat_freq = q[33:0];
    end
  endfunction

  state_t      state;
  state_t      next_state;
  state_t      rearm_state;

  logic [27:0] timer;
  logic [27:0] test_smp;
  logic [27:0] divisor;
  logic [55:0] div_q;       // dividend shifts out the top, quotient shifts in
  logic [27:0] div_rem;
  logic [5:0]  div_cnt;

  logic        accept_start;
  logic        do_range_up;
  logic        do_range_dn;
  logic        do_err;
  logic        do_load;
  logic        div_last;

  logic [28:0] rem_shift;
  logic [28:0] rem_diff;
  logic        q_bit;
  logic [27:0] rem_next;
  logic [55:0] quot_next;
  logic [55:0] product;

  // After a result or a zero-count error the run either re-arms or idles.
  assign rearm_state = cont_mode ? ST_LEAD : ST_IDLE;
  assign product     = 56'(CLK_STAND_FREQ) * 56'(cnt_test_reg);

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and one-cycle action strobes; abort overrides everything.
  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    do_range_up  = 1'b0;
    do_range_dn  = 1'b0;
    do_err       = 1'b0;
    do_load      = 1'b0;
    div_last     = 1'b0;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            next_state   = ST_LEAD;
            accept_start = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
        ST_LEAD: begin
          if (timer == 28'd0) begin
            next_state = ST_GATE;
          end else begin
            next_state = ST_LEAD;
          end
        end
        ST_GATE: begin
          if (timer == 28'd0) begin
            next_state = ST_SETTLE;
          end else begin
            next_state = ST_GATE;
          end
        end
        ST_SETTLE: begin
          if (timer == 28'd0) begin
            next_state = ST_CHECK;
          end else begin
            next_state = ST_SETTLE;
          end
        end
        ST_CHECK: begin
          if (cnt_stand_reg == 28'd0) begin
            do_err     = 1'b1;
            next_state = rearm_state;
          end else if (auto_en && (cnt_test_reg < MIN_CNT) && (range_cur != 2'd3)) begin
            do_range_up = 1'b1;
            next_state  = ST_LEAD;
          end else begin
            do_load    = 1'b1;
            next_state = ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_cnt == 6'd55) begin
            div_last   = 1'b1;
            next_state = ST_DONE;
          end else begin
            next_state = ST_DIV;
          end
        end
        ST_DONE: begin
          next_state = rearm_state;
          if (auto_en && (test_smp >= MAX_CNT) && (range_cur != 2'd0)) begin
            do_range_dn = 1'b1;
          end else begin
            do_range_dn = 1'b0;
          end
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // One restoring-division step. The divisor is never zero here, so the
  // remainder stays below it and the shifted remainder is below 2*divisor:
  // bit 28 of the difference is therefore exactly the borrow.
  always_comb begin
    rem_shift = {div_rem, div_q[55]};
    rem_diff  = rem_shift - {1'b0, divisor};
    q_bit     = ~rem_diff[28];
    if (q_bit) begin
      rem_next = rem_diff[27:0];
    end else begin
      rem_next = rem_shift[27:0];
    end
    quot_next = {div_q[54:0], q_bit};
  end

  // Shared down-timer: loaded with length-1 on entry to LEAD/GATE/SETTLE,
  // the state is left on the cycle the timer reads zero.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      timer <= 28'd0;
    end else if (next_state != state) begin
      case (next_state)
        ST_LEAD:   timer <= LEAD_CYC - 28'd1;
        ST_GATE:   timer <= gate_len(range_cur) - 28'd1;
        ST_SETTLE: timer <= SETTLE_CYC - 28'd1;
        default:   timer <= 28'd0;
      endcase
    end else if (timer != 28'd0) begin
      timer <= timer - 28'd1;
    end else begin
      timer <= timer;
    end
  end

  // Active range: loaded on start, stepped up in CHECK, stepped down in DONE.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      range_cur <= 2'd0;
    end else if (accept_start) begin
      range_cur <= range_init;
    end else if (do_range_up) begin
      range_cur <= range_cur + 2'd1;
    end else if (do_range_dn) begin
      range_cur <= range_cur - 2'd1;
    end else begin
      range_cur <= range_cur;
    end
  end

  // Divider datapath: loaded from the sampled counts, then one bit per cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_q    <= 56'd0;
      div_rem  <= 28'd0;
      div_cnt  <= 6'd0;
      divisor  <= 28'd0;
      test_smp <= 28'd0;
    end else if (do_load) begin
      div_q    <= product;
      div_rem  <= 28'd0;
      div_cnt  <= 6'd0;
      divisor  <= cnt_stand_reg;
      test_smp <= cnt_test_reg;
    end else if (state == ST_DIV) begin
      div_q    <= quot_next;
      div_rem  <= rem_next;
      div_cnt  <= div_cnt + 6'd1;
    end else begin
      div_q    <= div_q;
      div_rem  <= div_rem;
      div_cnt  <= div_cnt;
      divisor  <= divisor;
      test_smp <= test_smp;
    end
  end

  // Registered outputs; freq is written from the final divider step so it is
  // valid in the same cycle as the freq_valid pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gate_s     <= 1'b0;
      busy       <= 1'b0;
      freq       <= 34'd0;
      freq_valid <= 1'b0;
      err_zero   <= 1'b0;
    end else begin
      gate_s     <= (next_state == ST_GATE);
      busy       <= (next_state != ST_IDLE);
      freq_valid <= div_last;
      err_zero   <= do_err;
      if (div_last) begin
        freq <= sat_freq(quot_next);
      end else begin
        freq <= freq;
      end
    end
  end

endmodule

// File: tb/tb_freq_meas_seq.sv
// -----------------------------------------------------------------------------
// tb_freq_meas_seq
//   Self-checking bench for freq_meas_seq with shortened timing parameters.
//   Expected results come from an arithmetic reference model of the
//   measurement rules (latency sums, quotient with saturation, range steps).
// -----------------------------------------------------------------------------
module tb_freq_meas_seq;

  localparam logic [27:0] CLK_STAND = 28'd60_000_000;
  localparam int GB   = 10;
  localparam int LD   = 4;
  localparam int ST   = 4;
  localparam int MINC = 5;
  localparam int MAXC = 1000;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic        abort;
  logic        cont_mode;
  logic        auto_en;
  logic [1:0]  range_init;
  logic [27:0] cnt_test_reg;
  logic [27:0] cnt_stand_reg;
  logic        gate_s;
  logic        busy;
  logic [1:0]  range_cur;
  logic [33:0] freq;
  logic        freq_valid;
  logic        err_zero;

  int n_checks = 0;
  int n_pass   = 0;
  logic [33:0] last_freq = 34'd0;

  freq_meas_seq #(
    .CLK_STAND_FREQ(CLK_STAND),
    .GATE_BASE     (28'd10),
    .LEAD_CYC      (28'd4),
    .SETTLE_CYC    (28'd4),
    .MIN_CNT       (28'd5),
    .MAX_CNT       (28'd1000)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .abort        (abort),
    .cont_mode    (cont_mode),
    .auto_en      (auto_en),
    .range_init   (range_init),
    .cnt_test_reg (cnt_test_reg),
    .cnt_stand_reg(cnt_stand_reg),
    .gate_s       (gate_s),
    .busy         (busy),
    .range_cur    (range_cur),
    .freq         (freq),
    .freq_valid   (freq_valid),
    .err_zero     (err_zero)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [33:0] ref_freq(input logic [27:0] t, input logic [27:0] s);
    logic [63:0] q;
    q = (64'(CLK_STAND) * 64'(t)) / 64'(s);
    return (q >= 64'h4_0000_0000) ? 34'h3_FFFF_FFFF : q[33:0];
  endfunction

  function automatic int gate_len(input int r);
    return GB << (2 * r);
  endfunction

  // Single-shot run; t0 is the count for the first pass, t1 for later passes.
  task automatic run_single(input string tag, input logic [27:0] t0, input logic [27:0] t1,
                            input logic [27:0] s, input logic [1:0] rinit, input logic au);
    int r, passes, exp_idx, idx, got_idx, gates, gate_cnt, exp_r;
    logic [27:0] tf;
    logic        is_err, prev_gate;
    logic [33:0] exp_f;
    r = int'(rinit); passes = 1; tf = t0; is_err = (s == 28'd0);
    exp_idx = LD;
    if (!is_err) begin
      while (au && (int'(tf) < MINC) && r < 3) begin
        exp_idx += gate_len(r) + ST + 1 + LD;
        r++; passes++; tf = t1;
      end
    end
    exp_idx += gate_len(r) + ST + 1 + (is_err ? 1 : 57);
    exp_f = is_err ? last_freq : ref_freq(tf, s);
    exp_r = (!is_err && au && (int'(tf) >= MAXC) && r > 0) ? r - 1 : r;

    cnt_test_reg = t0; cnt_stand_reg = s; range_init = rinit; auto_en = au; cont_mode = 1'b0;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    idx = 1; got_idx = -1; gates = 0; gate_cnt = 0; prev_gate = 1'b0;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    while (got_idx < 0 && idx <= exp_idx + 40) begin
      if (gate_s && !prev_gate) begin
        gates++;
        gate_cnt = 0;
        if (gates == 2) cnt_test_reg = t1;
      end
      if (gate_s) gate_cnt++;
      prev_gate = gate_s;
      if (freq_valid || err_zero) begin
        got_idx = idx;
      end else begin
        @(negedge sys_clk);
        idx++;
      end
    end
    chk({tag, " latency"}, 64'(got_idx), 64'(exp_idx));
    chk({tag, " flags"}, 64'({freq_valid, err_zero}), 64'({~is_err, is_err}));
    chk({tag, " freq"}, 64'(freq), 64'(exp_f));
    chk({tag, " gate_len"}, 64'(gate_cnt), 64'(gate_len(r)));
    chk({tag, " passes"}, 64'(gates), 64'(passes));
    chk({tag, " range"}, 64'(range_cur), 64'(r));
    last_freq = exp_f;
    @(negedge sys_clk);
    chk({tag, " pulse_end"}, 64'({freq_valid, err_zero}), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
    chk({tag, " range_after"}, 64'(range_cur), 64'(exp_r));
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    int fv_idx[3];
    int n_fv, idx, extra;
    logic [27:0] t0, t1, s;

    sys_rst = 1'b1; start = 1'b0; abort = 1'b0; cont_mode = 1'b0; auto_en = 1'b0;
    range_init = 2'd0; cnt_test_reg = 28'd0; cnt_stand_reg = 28'd0;
    repeat (3) @(negedge sys_clk);
    chk("reset_outputs", 64'({gate_s, busy, range_cur, freq, freq_valid, err_zero}), 64'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Basic measurement, zero standard count, auto-range up, saturation, range down.
    run_single("basic", 28'd1_000_000, 28'd1_000_000, 28'd6_000_000, 2'd0, 1'b0);
    run_single("zero_stand", 28'd1_000, 28'd1_000, 28'd0, 2'd0, 1'b0);
    run_single("auto_up", 28'd3, 28'd500, 28'd6_000_000, 2'd0, 1'b1);
    run_single("saturate", 28'hFFF_FFFF, 28'hFFF_FFFF, 28'd1, 2'd0, 1'b0);
    run_single("auto_down", 28'd5_000, 28'd5_000, 28'd3_000, 2'd2, 1'b1);

    // Abort during GATE, with an ignored start while busy.
    cnt_test_reg = 28'd1_000_000; cnt_stand_reg = 28'd6_000_000; auto_en = 1'b0;
    range_init = 2'd1; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    range_init = 2'd3; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("start_ignored", 64'(range_cur), 64'd1);
    for (int i = 0; i < 50 && !gate_s; i++) @(negedge sys_clk);
    chk("abort_gate_seen", 64'(gate_s), 64'd1);
    repeat (3) @(negedge sys_clk);
    abort = 1'b1;
    @(negedge sys_clk);
    chk("abort_gate_low", 64'(gate_s), 64'd0);
    chk("abort_busy_low", 64'(busy), 64'd0);
    abort = 1'b0;
    extra = 0;
    for (int i = 0; i < 150; i++) begin
      if (freq_valid || err_zero) extra++;
      @(negedge sys_clk);
    end
    chk("abort_no_result", 64'(extra), 64'd0);
    chk("abort_freq_held", 64'(freq), 64'(last_freq));
    range_init = 2'd0; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("restart_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    @(negedge sys_clk);

    // Randomized single-shot runs against the model.
    for (int i = 0; i < 10; i++) begin
      t0 = ($urandom_range(0, 1) == 0) ? 28'($urandom_range(0, 20)) : 28'($urandom);
      t1 = 28'($urandom);
      s  = 28'($urandom_range(32'd1, 32'h0FFF_FFFF));
      run_single("rand", t0, t1, s, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Continuous mode, then dropping cont_mode mid-run.
    cnt_test_reg = 28'd1_000_000; cnt_stand_reg = 28'd6_000_000; range_init = 2'd0;
    auto_en = 1'b0; cont_mode = 1'b1; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    fv_idx = '{-1000, -1000, -1000};
    idx = 1; n_fv = 0;
    while (n_fv < 3 && idx < 400) begin
      if (freq_valid) begin
        fv_idx[n_fv] = idx;
        n_fv++;
      end
      if (n_fv == 2 && idx == fv_idx[1] + 10) cont_mode = 1'b0;
      if (n_fv < 3) begin
        @(negedge sys_clk);
        idx++;
      end
    end
    chk("cont_count", 64'(n_fv), 64'd3);
    chk("cont_first", 64'(fv_idx[0]), 64'(LD + GB + ST + 1 + 56 + 1));
    chk("cont_gap1", 64'(fv_idx[1] - fv_idx[0]), 64'(LD + GB + ST + 1 + 56 + 1));
    chk("cont_gap2", 64'(fv_idx[2] - fv_idx[1]), 64'(LD + GB + ST + 1 + 56 + 1));
    chk("cont_freq", 64'(freq), 64'(ref_freq(28'd1_000_000, 28'd6_000_000)));
    @(negedge sys_clk);
    chk("cont_stop_idle", 64'(busy), 64'd0);
    extra = 0;
    for (int i = 0; i < 120; i++) begin
      if (freq_valid || busy) extra++;
      @(negedge sys_clk);
    end
    chk("cont_stopped", 64'(extra), 64'd0);

    // Reset while dividing.
    range_init = 2'd2; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (199) @(negedge sys_clk);
    chk("div_busy", 64'(busy), 64'd1);
    chk("div_range", 64'(range_cur), 64'd2);
    sys_rst = 1'b1;
    #1;
    chk("rst_in_div", 64'({gate_s, busy, range_cur, freq, freq_valid, err_zero}), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_stays_idle", 64'({busy, freq_valid}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
